// File: rtl/uart_frame_matcher.sv
// Purpose : assemble fixed-length frames from a UART RX byte stream, drop partial
//           frames on inter-byte timeout, and set/clear per-channel flags by key match.
// Latency : frame_valid is high in the 2nd cycle after the edge that accepts the last byte.
// Backpr. : rx_ready drops for the single EVAL cycle after each frame; no byte is lost.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   rx_data/valid   incoming byte, qualified by rx_valid & rx_ready
//   rx_ready        low only while the completed frame is being evaluated
//   set_key/clr_key channel i key in bits [i*DBITS +: DBITS]
//   frame_out       last complete frame, first received byte in the LSBs
//   frame_valid     one-cycle pulse when frame_out/flags update
//   flags           per-channel flag state
//   err_timeout     one-cycle pulse when a partial frame is discarded
//   frame_count     number of complete frames, wraps at 16 bits
module uart_frame_matcher #(
   parameter int DBITS          = 8,
   parameter int FRAME_BYTES    = 4,
   parameter int NUM_FLAGS      = 2,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DBITS-1:0]              rx_data,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   input  logic [NUM_FLAGS*DBITS-1:0]    set_key,
   input  logic [NUM_FLAGS*DBITS-1:0]    clr_key,
   output logic [FRAME_BYTES*DBITS-1:0]  frame_out,
   output logic                          frame_valid,
   output logic [NUM_FLAGS-1:0]          flags,
   output logic                          err_timeout,
   output logic [15:0]                   frame_count
);

   // Index needs at least one bit even for single-byte frames.
   localparam int IW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EVAL    = 2'd2
   } state_t;

   state_t                         state_q, state_d;
   logic [IW-1:0]                  idx_q, idx_d;
   logic [TW-1:0]                  tcnt_q, tcnt_d;
   logic [FRAME_BYTES*DBITS-1:0]   buf_q, buf_d;
   logic                           rx_ready_q, rx_ready_d;
   logic [FRAME_BYTES*DBITS-1:0]   frame_out_q, frame_out_d;
   logic                           frame_valid_q, frame_valid_d;
   logic [NUM_FLAGS-1:0]           flags_q, flags_d;
   logic                           err_q, err_d;
   logic [15:0]                    count_q, count_d;

   logic                           hs;
   logic [DBITS-1:0]               first_b, last_b;
   logic [NUM_FLAGS-1:0]           set_hit, clr_hit;

   assign hs      = rx_valid & rx_ready_q;
   assign first_b = buf_q[DBITS-1:0];
   assign last_b  = buf_q[(FRAME_BYTES-1)*DBITS +: DBITS];

   // Key match per channel; with one-byte frames first_b and last_b are the same byte.
   always_comb begin
      set_hit = '0;
      clr_hit = '0;
      for (int i = 0; i < NUM_FLAGS; i++) begin
         set_hit[i] = (first_b == set_key[i*DBITS +: DBITS]) &&
                      (last_b  == set_key[i*DBITS +: DBITS]);
         clr_hit[i] = (first_b == clr_key[i*DBITS +: DBITS]) &&
                      (last_b  == clr_key[i*DBITS +: DBITS]);
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      tcnt_d        = tcnt_q;
      buf_d         = buf_q;
      frame_out_d   = frame_out_q;
      frame_valid_d = 1'b0;
      flags_d       = flags_q;
      err_d         = 1'b0;
      count_d       = count_q;

      case (state_q)
         IDLE: begin
            // No timeout is armed until the first byte of a frame arrives.
            tcnt_d = '0;
            if (hs) begin
               buf_d[DBITS-1:0] = rx_data;
               if (FRAME_BYTES == 1) begin
                  state_d = EVAL;
                  idx_d   = '0;
               end else begin
                  state_d = COLLECT;
                  idx_d   = IW'(1);
               end
            end
         end

         COLLECT: begin
            // A byte arriving on the terminal count takes priority over the timeout.
            if (hs) begin
               buf_d[int'(idx_q)*DBITS +: DBITS] = rx_data;
               tcnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = EVAL;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (tcnt_q == TO_LAST) begin
               state_d = IDLE;
               idx_d   = '0;
               tcnt_d  = '0;
               err_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end

         EVAL: begin
            frame_out_d   = buf_q;
            frame_valid_d = 1'b1;
            count_d       = count_q + 16'd1;
            for (int i = 0; i < NUM_FLAGS; i++) begin
               if (clr_hit[i]) begin
                  flags_d[i] = 1'b0;
               end else if (set_hit[i]) begin
                  flags_d[i] = 1'b1;
               end
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            idx_d   = '0;
            tcnt_d  = '0;
         end
      endcase

      // Registered ready: low exactly for the cycle spent in EVAL.
      rx_ready_d = (state_d != EVAL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         tcnt_q        <= '0;
         buf_q         <= '0;
         rx_ready_q    <= 1'b1;
         frame_out_q   <= '0;
         frame_valid_q <= 1'b0;
         flags_q       <= '0;
         err_q         <= 1'b0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         tcnt_q        <= tcnt_d;
         buf_q         <= buf_d;
         rx_ready_q    <= rx_ready_d;
         frame_out_q   <= frame_out_d;
         frame_valid_q <= frame_valid_d;
         flags_q       <= flags_d;
         err_q         <= err_d;
         count_q       <= count_d;
      end
   end

   assign rx_ready    = rx_ready_q;
   assign frame_out   = frame_out_q;
   assign frame_valid = frame_valid_q;
   assign flags       = flags_q;
   assign err_timeout = err_q;
   assign frame_count = count_q;

endmodule

// File: tb/tb_uart_frame_matcher.sv
// Purpose : self-checking bench for uart_frame_matcher (4-byte frames, 2 channels, timeout 16).
// Latency : checks frame_valid two cycles after the last accepted byte.
// Backpr. : drives rx_valid and waits (bounded) on rx_ready before each byte.
module tb_uart_frame_matcher;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] set_key;
   logic [15:0] clr_key;
   logic [31:0] frame_out;
   logic        frame_valid;
   logic [1:0]  flags;
   logic        err_timeout;
   logic [15:0] frame_count;

   uart_frame_matcher #(
      .DBITS(8), .FRAME_BYTES(4), .NUM_FLAGS(2), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .set_key(set_key), .clr_key(clr_key),
      .frame_out(frame_out), .frame_valid(frame_valid), .flags(flags),
      .err_timeout(err_timeout), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] frame;
      logic [1:0]  flg;
      logic [15:0] cnt;
   } exp_t;
   exp_t exp_q[$];
   int   model_cnt = 0;
   int   waits[8];

   typedef struct {
      logic [31:0] bytes;     // byte0 in [7:0], sent first
      logic [15:0] skey;      // {ch1, ch0}
      logic [15:0] ckey;
      logic [31:0] exp_frame;
      logic [1:0]  exp_flags;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: each frame_valid pulse pops the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && frame_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_frame_valid", 48'd1, 48'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_frame_out", 48'(frame_out), 48'(e.frame));
            check("sb_flags", 48'(flags), 48'(e.flg));
            check("sb_frame_count", 48'(frame_count), 48'(e.cnt));
         end
      end
   end

   // Called at a negedge; returns at the negedge just after the byte is accepted.
   task automatic send_byte(input logic [7:0] b, output int w);
      w = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (w >= 10) check("rx_ready_wait_bound", 48'd0, 48'd1);
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [31:0] f, input logic [1:0] fl);
      exp_t e;
      model_cnt++;
      e.frame = f;
      e.flg   = fl;
      e.cnt   = 16'(model_cnt);
      exp_q.push_back(e);
   endtask

   task automatic send_frame(input logic [31:0] f, input logic [31:0] ef, input logic [1:0] efl);
      int w;
      for (int i = 0; i < 3; i++) send_byte(f[i*8 +: 8], w);
      push_exp(ef, efl);
      send_byte(f[31:24], w);
      rx_valid = 1'b0;
      check("lat_not_yet", 48'(frame_valid), 48'd0);
      check("eval_rx_ready_low", 48'(rx_ready), 48'd0);
      @(negedge clk);
      check("lat_pulse", 48'(frame_valid), 48'd1);
      check("rx_ready_back", 48'(rx_ready), 48'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w;
      int  seen;
      logic [31:0] fo_keep;

      vecs[0] = '{32'h41000041, 16'hAA41, 16'hBB43, 32'h41000041, 2'b01};
      vecs[1] = '{32'h43341243, 16'hAA41, 16'hBB43, 32'h43341243, 2'b00};
      vecs[2] = '{32'h41889941, 16'hAA41, 16'hBB43, 32'h41889941, 2'b01};
      vecs[3] = '{32'hAA0201AA, 16'hAA41, 16'hBB43, 32'hAA0201AA, 2'b11};
      vecs[4] = '{32'h55776655, 16'h5541, 16'h5543, 32'h55776655, 2'b01};
      vecs[5] = '{32'h42000041, 16'hAA41, 16'hBB43, 32'h42000041, 2'b01};
      vecs[6] = '{32'h43000043, 16'hAA41, 16'hBB43, 32'h43000043, 2'b00};

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      set_key  = 16'hAA41;
      clr_key  = 16'hBB43;
      #12;
      check("rst_rx_ready", 48'(rx_ready), 48'd1);
      check("rst_frame_out", 48'(frame_out), 48'd0);
      check("rst_frame_valid", 48'(frame_valid), 48'd0);
      check("rst_flags", 48'(flags), 48'd0);
      check("rst_err", 48'(err_timeout), 48'd0);
      check("rst_count", 48'(frame_count), 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven frames, including clear-wins on channel 1 (vector 4).
      for (int v = 0; v < 7; v++) begin
         set_key = vecs[v].skey;
         clr_key = vecs[v].ckey;
         send_frame(vecs[v].bytes, vecs[v].exp_frame, vecs[v].exp_flags);
         repeat (3) @(negedge clk);
      end
      drain();
      set_key = 16'hAA41;
      clr_key = 16'hBB43;

      // Timeout: two bytes then idle; pulse on the 16th idle edge, state untouched.
      fo_keep = frame_out;
      send_byte(8'h41, w);
      send_byte(8'h41, w);
      rx_valid = 1'b0;
      seen = 0;
      repeat (TO - 1) begin
         @(negedge clk);
         if (err_timeout) seen++;
      end
      check("timeout_not_early", 48'(seen), 48'd0);
      @(negedge clk);
      check("timeout_pulse", 48'(err_timeout), 48'd1);
      @(negedge clk);
      check("timeout_one_cycle", 48'(err_timeout), 48'd0);
      check("timeout_flags_kept", 48'(flags), 48'd0);
      check("timeout_frame_kept", 48'(frame_out), 48'(fo_keep));
      check("timeout_count_kept", 48'(frame_count), 48'd7);
      send_frame(32'h44020144, 32'h44020144, 2'b00);
      drain();

      // Byte arriving on the terminal-count cycle is kept, no error.
      send_byte(8'h41, w);
      send_byte(8'h41, w);
      rx_valid = 1'b0;
      seen = 0;
      repeat (TO - 1) begin
         @(negedge clk);
         if (err_timeout) seen++;
      end
      send_byte(8'h77, w);
      if (err_timeout) seen++;
      push_exp(32'h41774141, 2'b01);
      send_byte(8'h41, w);
      rx_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (err_timeout) seen++;
      end
      check("tc_race_no_err", 48'(seen), 48'd0);
      drain();

      // Back-to-back: rx_valid held, ready drops for one cycle after each 4th byte.
      push_exp(32'h13121110, 2'b01);
      push_exp(32'h23222120, 2'b01);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         b = 8'(((i / 4) + 1) * 16 + (i % 4));
         send_byte(b, waits[i]);
      end
      rx_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("b2b_wait_%0d", i), 48'(waits[i]), (i == 4) ? 48'd1 : 48'd0);
      end
      drain();
      check("b2b_count", 48'(frame_count), 48'd11);

      // Async reset mid-frame, then a fresh complete frame.
      send_byte(8'h99, w);
      send_byte(8'h98, w);
      rx_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_frame_out", 48'(frame_out), 48'd0);
      check("arst_flags", 48'(flags), 48'd0);
      check("arst_count", 48'(frame_count), 48'd0);
      check("arst_valid", 48'(frame_valid), 48'd0);
      check("arst_err", 48'(err_timeout), 48'd0);
      check("arst_rx_ready", 48'(rx_ready), 48'd1);
      model_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(32'h41000041, 32'h41000041, 2'b01);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
